counter_step_scheduler: RTL and testbench

Round-robin scheduler that shares one 8-bit up/down counter between NREQ requesters. Each requester asks for a burst of up or down steps. The scheduler grants one requester at a time and drives the counter's enable, direction and clear controls for the length of that burst. It watches the counter's overflow and underflow flags and reports a per-burst wrap indication when the burst completes. It sits directly in front of the counter datapath, and every counter control originates here.

---
 rtl/counter_step_scheduler_if.sv | 30 +++
 rtl/counter_step_scheduler.sv | 143 ++++++++++++++
 tb/tb_counter_step_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_step_scheduler_if.sv
// Requester and counter-control bundle for counter_step_scheduler.
// The slave modport is the scheduler. The master modport is the requesters plus the counter datapath.
interface counter_step_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int LEN_W = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       req_dir;
   logic [NREQ*LEN_W-1:0] req_len;
   logic                  clear_req;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  done_wrap;
   logic                  done_abort;
   logic                  cnt_enable;
   logic                  cnt_up_down;
   logic                  cnt_clear;
   logic                  ovf_in;
   logic                  unf_in;

   modport slave (
      input  req, req_dir, req_len, clear_req, ovf_in, unf_in,
      output gnt, done, done_wrap, done_abort, cnt_enable, cnt_up_down, cnt_clear
   );

   modport master (
      output req, req_dir, req_len, clear_req, ovf_in, unf_in,
      input  gnt, done, done_wrap, done_abort, cnt_enable, cnt_up_down, cnt_clear
   );
endinterface

// File: rtl/counter_step_scheduler.sv
// Round-robin scheduler that time-shares one 8-bit up/down counter among NREQ burst requesters.
// It reports per-burst wrap and abort status on a one-cycle done pulse.
module counter_step_scheduler #(
   parameter int NREQ  = 4,
   parameter int LEN_W = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   counter_step_scheduler_if.slave   bus
);

   localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             dir_q, dir_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             wrap_q, wrap_d;
   logic             abort_q, abort_d;

   logic [SEL_W-1:0] pick;
   logic             found;
   logic [NREQ-1:0]  sel_onehot;

   function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return SEL_W'(s);
   endfunction

   // The search starts at ptr+1, so the most recently served requester ranks last.
   always_comb begin : rr_pick
      logic [SEL_W-1:0] cand;
      cand  = '0;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = rr_index(ptr_q, k);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // NOTE: every signal gets a default before the case statement. This way no path leaves a value held, and no latch is inferred.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      wrap_d  = wrap_q;
      abort_d = abort_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.clear_req) begin
               state_d = ST_CLEAR;
            end else if (found) begin
               sel_d   = pick;
               dir_d   = bus.req_dir[pick];
               rem_d   = bus.req_len[int'(pick)*LEN_W +: LEN_W];
               wrap_d  = 1'b0;
               abort_d = 1'b0;
               state_d = ST_BURST;
            end
         end
         ST_CLEAR: state_d = ST_IDLE;
         ST_BURST: begin
            if (!bus.req[sel_q]) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               rem_d = rem_q - 1'b1;
               if ((dir_q && bus.ovf_in) || (!dir_q && bus.unf_in)) wrap_d = 1'b1;
               if (rem_q == '0) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ptr_d   = sel_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sel_onehot = NREQ'(1) << sel_q;

   always_comb begin
      bus.gnt         = '0;
      bus.done        = '0;
      bus.done_wrap   = 1'b0;
      bus.done_abort  = 1'b0;
      bus.cnt_enable  = 1'b0;
      bus.cnt_up_down = 1'b0;
      bus.cnt_clear   = 1'b0;
      case (state_q)
         ST_CLEAR: bus.cnt_clear = 1'b1;
         ST_BURST: begin
            bus.gnt         = sel_onehot;
            bus.cnt_enable  = bus.req[sel_q];
            bus.cnt_up_down = dir_q;
         end
         ST_DONE: begin
            bus.gnt        = sel_onehot;
            bus.done       = sel_onehot;
            bus.done_wrap  = wrap_q;
            bus.done_abort = abort_q;
         end
         default: ;
      endcase
   end

   // NOTE: state flops use non-blocking assignments, so every flop samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         ptr_q   <= SEL_W'(NREQ - 1);
         dir_q   <= 1'b0;
         rem_q   <= '0;
         wrap_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
         wrap_q  <= wrap_d;
         abort_q <= abort_d;
      end
   end

endmodule

// File: tb/tb_counter_step_scheduler.sv
// Scoreboard bench for counter_step_scheduler. It drives a behavioural 8-bit counter and checks every burst,
// via its done pulse, against arithmetic expectations.
module tb_counter_step_scheduler;

   localparam int NREQ  = 4;
   localparam int LEN_W = 4;
   localparam int LEN_MAX = (1 << LEN_W) - 1;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   counter_step_scheduler_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

   counter_step_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Counter datapath that the scheduler controls.
   logic [7:0] cnt_val;
   logic       preset_en;
   logic [7:0] preset_val;

   always @(posedge clk) begin
      if (preset_en)           cnt_val <= preset_val;
      else if (bus.cnt_clear)  cnt_val <= 8'd0;
      else if (bus.cnt_enable) cnt_val <= bus.cnt_up_down ? cnt_val + 8'd1 : cnt_val - 8'd1;
   end

   assign bus.ovf_in = bus.cnt_enable && bus.cnt_up_down && (cnt_val == 8'hFF);
   assign bus.unf_in = bus.cnt_enable && (cnt_val == 8'h00);

   typedef struct {
      int idx;
      bit wrap;
      bit abort_;
      int steps;
      int cnt;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   model_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected outcome of one burst, derived from the start count and the step count.
   task automatic push_exp(input int idx, input bit d, input int steps, input bit ab, input int done_cyc);
      exp_t e;
      e.idx    = idx;
      e.abort_ = ab;
      e.steps  = steps;
      e.wrap   = d ? (model_cnt + steps > 255) : (model_cnt < steps);
      model_cnt = d ? (model_cnt + steps) % 256 : (model_cnt - steps + 256) % 256;
      e.cnt    = model_cnt;
      e.cyc    = done_cyc;
      exp_q.push_back(e);
   endtask

   // Monitor: counts enables and pops one expectation on each done pulse.
   int en_cnt = 0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         en_cnt = 0;
      end else begin
         if (bus.cnt_enable) begin
            en_cnt++;
            check("enable_without_gnt", int'(bus.gnt != '0), 1);
         end
         if (bus.done != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", int'(bus.done), 0);
            end else begin
               e = exp_q.pop_front();
               check("done_onehot", int'(bus.done), 1 << e.idx);
               check("done_gnt",    int'(bus.gnt),  1 << e.idx);
               check("done_cycle",  cyc,            e.cyc);
               check("done_wrap",   int'(bus.done_wrap),  int'(e.wrap));
               check("done_abort",  int'(bus.done_abort), int'(e.abort_));
               check("burst_steps", en_cnt, e.steps);
               check("counter_val", int'(cnt_val), e.cnt);
            end
            en_cnt = 0;
         end
      end
   end

   task automatic preset(input int v);
      @(posedge clk); #1;
      preset_en  = 1'b1;
      preset_val = 8'(v);
      @(posedge clk); #1;
      preset_en  = 1'b0;
      model_cnt  = v;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (bus.done == '0 && n < budget);
      check("done_seen", int'(bus.done != '0), 1);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, int'({bus.gnt, bus.done, bus.done_wrap, bus.done_abort,
                        bus.cnt_enable, bus.cnt_up_down, bus.cnt_clear}), 0);
   endtask

   // ab < 0 means run to completion. Otherwise req drops after ab enables.
   task automatic do_burst(input int i, input bit d, input int len, input int ab, input int start);
      int t;
      preset(start);
      @(posedge clk); #1;
      bus.req_dir[i] = d;
      bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
      bus.req[i] = 1'b1;
      t = cyc;
      if (ab >= 0) push_exp(i, d, ab, 1'b1, t + ab + 2);
      else         push_exp(i, d, len + 1, 1'b0, t + len + 2);
      @(posedge clk); #1;
      check("gnt_latency", int'(bus.gnt), 1 << i);
      bus.req_dir = NREQ'($urandom);
      bus.req_len = (NREQ*LEN_W)'($urandom);
      if (ab >= 0) begin
         repeat (ab) begin @(posedge clk); #1; end
         bus.req[i] = 1'b0;
         wait_done(2);
      end else begin
         wait_done(len + 2);
         bus.req[i] = 1'b0;
      end
   endtask

   task automatic clear_test(input int len);
      int t;
      bit d;
      preset(77);
      @(posedge clk); #1;
      d = 1'($urandom);
      bus.req_dir[3] = d;
      bus.req_len[3*LEN_W +: LEN_W] = LEN_W'(len);
      bus.req[3]     = 1'b1;
      bus.clear_req  = 1'b1;
      t = cyc;
      model_cnt = 0;
      push_exp(3, d, len + 1, 1'b0, t + len + 4);
      @(posedge clk); #1;
      check("clear_pulse", int'(bus.cnt_clear), 1);
      check("clear_no_gnt", int'(bus.gnt), 0);
      bus.clear_req = 1'b0;
      @(posedge clk); #1;
      check("clear_one_cycle", int'(bus.cnt_clear), 0);
      @(posedge clk); #1;
      check("clear_gnt_delay", int'(bus.gnt), 8);
      wait_done(len + 2);
      bus.req[3] = 1'b0;
   endtask

   task automatic rr_test();
      int t;
      bit d0, d2;
      @(posedge clk); #1;
      d0 = 1'($urandom);
      d2 = 1'($urandom);
      bus.req_dir[0] = d0;
      bus.req_dir[2] = d2;
      bus.req_len[0*LEN_W +: LEN_W] = '0;
      bus.req_len[2*LEN_W +: LEN_W] = '0;
      bus.req[0] = 1'b1;
      bus.req[2] = 1'b1;
      t = cyc;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) push_exp(0, d0, 1, 1'b0, t + 2 + 3*k);
         else            push_exp(2, d2, 1, 1'b0, t + 2 + 3*k);
      end
      for (int k = 0; k < 4; k++) wait_done(4);
      bus.req[0] = 1'b0;
      bus.req[2] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int i, len, ab, start, r;
      bit d;
      reset         = 1'b1;
      bus.req       = '0;
      bus.req_dir   = '0;
      bus.req_len   = '0;
      bus.clear_req = 1'b0;
      preset_en     = 1'b1;
      preset_val    = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset_outputs");
      reset     = 1'b0;
      preset_en = 1'b0;
      @(posedge clk); #1;
      check_outputs_zero("idle_outputs");

      do_burst(1, 1'b1, 3, -1, 10);
      do_burst(0, 1'b1, 2, -1, 254);
      do_burst(2, 1'b0, 1, -1, 1);
      do_burst(3, 1'b1, 7, 3, 100);
      do_burst(1, 1'b0, LEN_MAX, -1, 5);
      do_burst(2, 1'b1, 0, -1, 0);
      do_burst(0, 1'b0, 0, -1, 0);
      do_burst(3, 1'b1, 4, 0, 200);

      for (int n = 0; n < 40; n++) begin
         i   = $urandom_range(0, NREQ - 1);
         d   = 1'($urandom);
         len = $urandom_range(0, LEN_MAX);
         ab  = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
         r   = $urandom_range(0, 3);
         case (r)
            0:       start = d ? 255 - $urandom_range(0, 3) : $urandom_range(0, 3);
            default: start = $urandom_range(0, 255);
         endcase
         do_burst(i, d, len, ab, start);
      end

      clear_test($urandom_range(0, LEN_MAX));

      preset(100);
      @(posedge clk); #1;
      bus.req_dir[1] = 1'b1;
      bus.req_len[1*LEN_W +: LEN_W] = LEN_W'(10);
      bus.req[1] = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      check_outputs_zero("reset_mid_burst");
      bus.req[1] = 1'b0;
      reset = 1'b0;
      preset($urandom_range(0, 255));
      rr_test();

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
